// File: rtl/conv_same_sequencer.sv
// conv_same_sequencer
// Control FSM for one 1-D convolution Z = X * Y on a shared MAC datapath.
//
// For each output index k, the FSM walks the valid overlap range of j.
// On each step it issues X/Y read addresses and the MAC enable/clear.
// It then writes the accumulator to Z once for that k.
// In SAME mode only the centred window of sizeX outputs is produced.
// Cropped indices cost no cycles at all.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start_i          start request, sampled only while idle
//   mode_i           0 = FULL, 1 = SAME (latched on start)
//   sizeX_i, sizeY_i operand lengths (latched on start)
//   busy_o           high while a run is in progress (LOAD..WRITE)
//   done_o           one-cycle completion pulse
//   addrX_o, addrY_o X/Y read addresses (j and k-j)
//   mac_en_o         accumulate X[addrX]*Y[addrY] this cycle
//   mac_clr_o        load the product instead of adding (first j of each k)
//   wr_en_o, addrZ_o write the accumulator to Z[addrZ]
module conv_same_sequencer #(
  parameter int DATAWIDTH = 5,
  parameter int ZWIDTH    = DATAWIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [DATAWIDTH-1:0] sizeX_i,
  input  logic [DATAWIDTH-1:0] sizeY_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DATAWIDTH-1:0] addrX_o,
  output logic [DATAWIDTH-1:0] addrY_o,
  output logic                 mac_en_o,
  output logic                 mac_clr_o,
  output logic                 wr_en_o,
  output logic [ZWIDTH-1:0]    addrZ_o
);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

  localparam logic [ZWIDTH-1:0] ONE_Z = ZWIDTH'(1);

  state_t               state;
  logic                 mode_q;
  logic [DATAWIDTH-1:0] size_x_q;
  logic [DATAWIDTH-1:0] size_y_q;
  logic [ZWIDTH-1:0]    k_q;
  logic [ZWIDTH-1:0]    j_q;
  logic [ZWIDTH-1:0]    jmax_q;

  logic [ZWIDTH-1:0]    size_x_z;
  logic [ZWIDTH-1:0]    size_y_z;
  logic [ZWIDTH-1:0]    lo;
  logic [ZWIDTH-1:0]    kstart;
  logic [ZWIDTH-1:0]    kend;
  logic [ZWIDTH-1:0]    k_sel;
  logic [ZWIDTH-1:0]    jmin_n;
  logic [ZWIDTH-1:0]    jmax_n;
  logic [ZWIDTH-1:0]    j_inc;
  logic [DATAWIDTH-1:0] y_first;
  logic [DATAWIDTH-1:0] y_step;

  // One shared j-range calculator.
  // k_sel is the k about to be entered:
  //   kstart when leaving LOAD, otherwise k+1 when leaving WRITE.
  // Only these two states consume the calculator's result.
  always_comb begin
    size_x_z = ZWIDTH'(size_x_q);
    size_y_z = ZWIDTH'(size_y_q);
    lo       = (size_y_z - ONE_Z) >> 1;
    kstart   = mode_q ? lo : '0;
    kend     = mode_q ? (lo + size_x_z - ONE_Z)
                      : (size_x_z + size_y_z - ONE_Z - ONE_Z);
    k_sel    = (state == LOAD) ? kstart : (k_q + ONE_Z);
    jmin_n   = (k_sel >= size_y_z) ? (k_sel - size_y_z + ONE_Z) : '0;
    jmax_n   = (k_sel < size_x_z - ONE_Z) ? k_sel : (size_x_z - ONE_Z);
    j_inc    = j_q + ONE_Z;
    // k-j always lies in [0, sizeY-1], so truncation to DATAWIDTH is lossless.
    y_first  = DATAWIDTH'(k_sel - jmin_n);
    y_step   = DATAWIDTH'(k_q - j_inc);
  end

  // Outputs are set on the same edge that enters the state they belong to.
  // As a result, every output is valid for the whole cycle that state occupies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      size_x_q  <= '0;
      size_y_q  <= '0;
      k_q       <= '0;
      j_q       <= '0;
      jmax_q    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      addrX_o   <= '0;
      addrY_o   <= '0;
      mac_en_o  <= 1'b0;
      mac_clr_o <= 1'b0;
      wr_en_o   <= 1'b0;
      addrZ_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            mode_q   <= mode_i;
            size_x_q <= sizeX_i;
            size_y_q <= sizeY_i;
            // An empty operand produces no output at all.
            if (sizeX_i == '0 || sizeY_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state  <= LOAD;
              busy_o <= 1'b1;
            end
          end
        end

        LOAD: begin
          k_q       <= kstart;
          j_q       <= jmin_n;
          jmax_q    <= jmax_n;
          addrX_o   <= DATAWIDTH'(jmin_n);
          addrY_o   <= y_first;
          mac_en_o  <= 1'b1;
          mac_clr_o <= 1'b1;
          state     <= MAC;
        end

        MAC: begin
          mac_clr_o <= 1'b0;
          if (j_q == jmax_q) begin
            mac_en_o <= 1'b0;
            wr_en_o  <= 1'b1;
            addrZ_o  <= mode_q ? (k_q - lo) : k_q;
            state    <= WRITE;
          end else begin
            j_q     <= j_inc;
            addrX_o <= DATAWIDTH'(j_inc);
            addrY_o <= y_step;
          end
        end

        WRITE: begin
          wr_en_o <= 1'b0;
          if (k_q == kend) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            k_q       <= k_sel;
            j_q       <= jmin_n;
            jmax_q    <= jmax_n;
            addrX_o   <= DATAWIDTH'(jmin_n);
            addrY_o   <= y_first;
            mac_en_o  <= 1'b1;
            mac_clr_o <= 1'b1;
            state     <= MAC;
          end
        end

        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_same_sequencer.sv
// tb_conv_same_sequencer
// Directed testbench for conv_same_sequencer.
//
// Each run records the following, counting cycles from the start-accept edge:
//   - every MAC cycle, encoded as clr*10000 + addrX*100 + addrY;
//   - every Z write address;
//   - the done_o cycle and the number of busy_o cycles.
// These are compared with hand-computed sequences.
module tb_conv_same_sequencer;

  localparam int DW = 5;
  localparam int ZW = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [DW-1:0] sizeX_i = '0;
  logic [DW-1:0] sizeY_i = '0;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] addrX_o;
  logic [DW-1:0] addrY_o;
  logic          mac_en_o;
  logic          mac_clr_o;
  logic          wr_en_o;
  logic [ZW-1:0] addrZ_o;

  conv_same_sequencer #(.DATAWIDTH(DW), .ZWIDTH(ZW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .sizeX_i  (sizeX_i),
    .sizeY_i  (sizeY_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .addrX_o  (addrX_o),
    .addrY_o  (addrY_o),
    .mac_en_o (mac_en_o),
    .mac_clr_o(mac_clr_o),
    .wr_en_o  (wr_en_o),
    .addrZ_o  (addrZ_o)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int gotMac[$];
  int gotWr[$];
  int expMac[$];
  int expWr[$];
  int doneCycle;
  int busyCount;
  int violations;
  int extraActivity;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic sampleCycle(input int c);
    if (mac_en_o && wr_en_o) violations++;
    if (mac_clr_o && !mac_en_o) violations++;
    if (mac_en_o) gotMac.push_back(int'(mac_clr_o) * 10000 + int'(addrX_o) * 100 + int'(addrY_o));
    if (wr_en_o) gotWr.push_back(int'(addrZ_o));
    if (busy_o) busyCount++;
    if (done_o && doneCycle < 0) doneCycle = c;
  endtask

  // restartAt: cycle in which start_i is pulsed again (-1 = never).
  // abortAt:   cycle in which rst_n is dropped (-1 = never).
  // Inputs are scrambled right after the accept edge to prove they were latched.
  task automatic applyStimulus(input logic mode, input int sx, input int sy,
                               input int restartAt, input int abortAt);
    gotMac.delete();
    gotWr.delete();
    doneCycle     = -1;
    busyCount     = 0;
    violations    = 0;
    extraActivity = 0;
    @(negedge clk);
    mode_i  = mode;
    sizeX_i = DW'(sx);
    sizeY_i = DW'(sy);
    start_i = 1'b1;
    for (int c = 1; c <= 100 && doneCycle < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_i = 1'b0;
        sizeX_i = 5'd9;
        sizeY_i = 5'd7;
        mode_i  = ~mode;
      end
      if (c == restartAt) start_i = 1'b1;
      if (c == restartAt + 1) start_i = 1'b0;
      sampleCycle(c);
      if (c == abortAt) begin
        checkOutput("abortInWrite", int'(wr_en_o), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abortOutputsZero",
                    int'({busy_o, done_o, addrX_o, addrY_o, mac_en_o, mac_clr_o, wr_en_o, addrZ_o}), 0);
        repeat (3) begin
          @(negedge clk);
          if (done_o || busy_o || mac_en_o || wr_en_o) extraActivity++;
        end
        checkOutput("abortQuiet", extraActivity, 0);
        rst_n = 1'b1;
        return;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (done_o || busy_o || mac_en_o || wr_en_o) extraActivity++;
    end
  endtask

  task automatic checkRun(input string tag, input int expDone, input int expBusy);
    checkOutput({tag, " macCount"}, gotMac.size(), expMac.size());
    for (int i = 0; i < expMac.size(); i++)
      checkOutput($sformatf("%s mac%0d", tag, i), (i < gotMac.size()) ? gotMac[i] : -1, expMac[i]);
    checkOutput({tag, " wrCount"}, gotWr.size(), expWr.size());
    for (int i = 0; i < expWr.size(); i++)
      checkOutput($sformatf("%s wr%0d", tag, i), (i < gotWr.size()) ? gotWr[i] : -1, expWr[i]);
    checkOutput({tag, " doneCycle"}, doneCycle, expDone);
    checkOutput({tag, " busyCycles"}, busyCount, expBusy);
    checkOutput({tag, " protocol"}, violations, 0);
    checkOutput({tag, " idleAfter"}, extraActivity, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    checkOutput("resetState",
                int'({busy_o, done_o, addrX_o, addrY_o, mac_en_o, mac_clr_o, wr_en_o, addrZ_o}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // FULL 3x2: k0 (0,0); k1 (0,1),(1,0); k2 (1,1),(2,0); k3 (2,1)
    expMac = '{10000, 10001, 100, 10101, 200, 10201};
    expWr  = '{0, 1, 2, 3};
    applyStimulus(1'b0, 3, 2, -1, -1);
    checkRun("full3x2", 12, 11);

    // SAME 3x3: lo=1, k=1..3 with 2,3,2 MAC cycles
    expMac = '{10001, 100, 10002, 101, 200, 10102, 201};
    expWr  = '{0, 1, 2};
    applyStimulus(1'b1, 3, 3, -1, -1);
    checkRun("same3x3", 12, 11);

    // Empty X: straight to DONE, nothing issued
    expMac.delete();
    expWr.delete();
    applyStimulus(1'b0, 0, 4, -1, -1);
    checkRun("zeroX", 1, 0);

    // SAME 1x1: single MAC and single write
    expMac = '{10000};
    expWr  = '{0};
    applyStimulus(1'b1, 1, 1, -1, -1);
    checkRun("same1x1", 4, 3);

    // FULL 3x2 with a second start during the first MAC of k1
    expMac = '{10000, 10001, 100, 10101, 200, 10201};
    expWr  = '{0, 1, 2, 3};
    applyStimulus(1'b0, 3, 2, 4, -1);
    checkRun("restart3x2", 12, 11);

    // SAME 4x3 aborted by reset during the first WRITE, then a clean FULL 2x2
    applyStimulus(1'b1, 4, 3, -1, 4);
    expMac = '{10000, 10001, 100, 10101};
    expWr  = '{0, 1, 2};
    applyStimulus(1'b0, 2, 2, -1, -1);
    checkRun("full2x2", 9, 8);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
